uart_alu_intf: RTL and testbench

- Sequencing stage between the UART receiver/transmitter pair and the combinational ALU in the TP2 UART design.
- Consumes received bytes as they arrive: operand A, then operand B, then opcode.
- Holds those values stable on the ALU inputs, captures the ALU result one cycle later and hands it to the transmitter as a single start pulse.
- Waits for transmit completion before accepting a new frame.

---
 rtl/uart_alu_intf.sv | 164 ++++++++++++++++
 tb/tb_uart_alu_intf.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_intf.sv
// uart_alu_intf: sequencing stage between a UART RX/TX pair and a combinational ALU.
// Collects operand A, operand B and opcode from successive received bytes. It then
// holds them on the ALU inputs for one settle cycle, captures the ALU result and
// issues a single transmit start pulse. New bytes are accepted again after the
// transmitter reports completion.
//
// Optional feature (macro UART_ALU_INTF_TIMEOUT_EN): an inter-byte timeout abandons
// a partial frame after TIMEOUT_CYCLES idle cycles in GET_B/GET_OP.
//
// Ports:
//   i_clk          system clock, rising edge
//   reset          asynchronous active-low reset
//   i_rx_done_tick receiver byte-valid pulse, with i_rx_data
//   o_data_a/b     registered operands to the ALU
//   o_operation    registered opcode to the ALU (low NB_OP bits of the opcode byte)
//   i_alu_result   combinational ALU result
//   o_tx_start     one-cycle transmit start pulse, with o_tx_data
//   i_tx_done_tick transmitter byte-sent pulse
//   o_busy         high while latching/transmitting
//   o_overrun      sticky: a byte was dropped while busy
//   o_timeout      one-cycle pulse when a partial frame is abandoned
module uart_alu_intf #(
  parameter int unsigned DBIT           = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_rx_done_tick,
  input  logic [DBIT-1:0]  i_rx_data,
  output logic [DBIT-1:0]  o_data_a,
  output logic [DBIT-1:0]  o_data_b,
  output logic [NB_OP-1:0] o_operation,
  input  logic [DBIT-1:0]  i_alu_result,
  output logic             o_tx_start,
  output logic [DBIT-1:0]  o_tx_data,
  input  logic             i_tx_done_tick,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_timeout
);

  typedef enum logic [2:0] {StGetA, StGetB, StGetOp, StLatch, StWaitTx} state_e;

  state_e           state_q, state_d;
  logic [DBIT-1:0]  data_a_q, data_a_d;
  logic [DBIT-1:0]  data_b_q, data_b_d;
  logic [NB_OP-1:0] op_q, op_d;
  logic [DBIT-1:0]  tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             overrun_q, overrun_d;
  logic             expire;

`ifdef UART_ALU_INTF_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q;
  logic            in_partial;

  assign in_partial = (state_q == StGetB) || (state_q == StGetOp);
  // Expiry is judged on the value the counter is about to take, so the pulse
  // lands TIMEOUT_CYCLES cycles after the last accepted byte. A byte in the
  // same cycle wins.
  assign expire = in_partial && !i_rx_done_tick && (cnt_q == CntW'(TIMEOUT_CYCLES - 2));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!in_partial || i_rx_done_tick || expire) cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= expire;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      StGetA: begin
        if (i_rx_done_tick) begin
          data_a_d = i_rx_data;
          state_d  = StGetB;
        end
      end
      StGetB: begin
        if (i_rx_done_tick) begin
          data_b_d = i_rx_data;
          state_d  = StGetOp;
        end else if (expire) begin
          state_d = StGetA;
        end
      end
      StGetOp: begin
        if (i_rx_done_tick) begin
          op_d    = i_rx_data[NB_OP-1:0];
          state_d = StLatch;
        end else if (expire) begin
          state_d = StGetA;
        end
      end
      StLatch: begin
        // Operands have been stable on the ALU for a full cycle here.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = StWaitTx;
        if (i_rx_done_tick) overrun_d = 1'b1;
      end
      StWaitTx: begin
        if (i_tx_done_tick) state_d = StGetA;
        if (i_rx_done_tick) overrun_d = 1'b1;
      end
      default: state_d = StGetA;
    endcase
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StGetA;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_data_a    = data_a_q;
  assign o_data_b    = data_b_q;
  assign o_operation = op_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q == StLatch) || (state_q == StWaitTx);

endmodule

// File: tb/tb_uart_alu_intf.sv
// Bench for uart_alu_intf with an A+B ALU stand-in. It covers table-driven frames,
// hand-written corner sequences and randomized frames against a frame-level model.
module tb_uart_alu_intf;

  logic       clk;
  logic       reset;
  logic       rx_tick;
  logic [7:0] rx_data;
  logic [7:0] data_a, data_b, tx_data, alu_result;
  logic [5:0] operation;
  logic       tx_start, tx_done, busy, overrun, timeout;

  int n_cmp = 0;
  int n_err = 0;
  int n_starts = 0;

  uart_alu_intf #(
    .DBIT          (8),
    .NB_OP         (6),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk         (clk),
    .reset         (reset),
    .i_rx_done_tick(rx_tick),
    .i_rx_data     (rx_data),
    .o_data_a      (data_a),
    .o_data_b      (data_b),
    .o_operation   (operation),
    .i_alu_result  (alu_result),
    .o_tx_start    (tx_start),
    .o_tx_data     (tx_data),
    .i_tx_done_tick(tx_done),
    .o_busy        (busy),
    .o_overrun     (overrun),
    .o_timeout     (timeout)
  );

  // ALU stand-in: 8-bit add, wraps.
  assign alu_result = data_a + data_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (tx_start) n_starts++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_tick = 1'b1;
    rx_data = b;
    step();
    rx_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rx_tick = 1'b0;
    tx_done = 1'b0;
    reset   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();
  endtask

  typedef struct {
    logic [7:0] a, b, op;
    logic [7:0] exp_a, exp_b;
    logic [5:0] exp_op;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int starts0;
    int hit;
    logic [7:0] ra, rb, rop;
    logic model_ovr;

    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h05, 8'h03, 6'h20, 8'h08};
    vecs[1] = '{8'h0A, 8'h02, 8'hE1, 8'h0A, 8'h02, 6'h21, 8'h0C};
    vecs[2] = '{8'hFF, 8'h01, 8'h3F, 8'hFF, 8'h01, 6'h3F, 8'h00};
    vecs[3] = '{8'h80, 8'h80, 8'hC0, 8'h80, 8'h80, 6'h00, 8'h00};
    vecs[4] = '{8'h12, 8'h34, 8'h7F, 8'h12, 8'h34, 6'h3F, 8'h46};

    rx_tick = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    reset   = 1'b0;
    #12;
    // Reset state while held in reset.
    check("rst_data_a", data_a, 0);
    check("rst_data_b", data_b, 0);
    check("rst_op", operation, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_flags", {tx_start, busy, overrun, timeout}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Table-driven frames, bytes 20 cycles apart.
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].a);
      repeat (19) step();
      send_byte(vecs[i].b);
      repeat (19) step();
      send_byte(vecs[i].op);
      check("vec_data_a", data_a, vecs[i].exp_a);
      check("vec_data_b", data_b, vecs[i].exp_b);
      check("vec_op", operation, vecs[i].exp_op);
      check("vec_latch_busy_start", {busy, tx_start}, 2'b10);
      step();
      check("vec_start_k2", tx_start, 1);
      check("vec_tx_data", tx_data, vecs[i].exp_tx);
      step();
      check("vec_start_one_cycle", {busy, tx_start}, 2'b10);
      repeat (3) step();
      check("vec_busy_wait", busy, 1);
      pulse_tx_done();
      check("vec_busy_done", busy, 0);
      check("vec_no_overrun", overrun, 0);
      repeat (3) step();
    end

    // Overrun during WAIT_TX.
    send_byte(8'h0A);
    send_byte(8'h02);
    send_byte(8'h20);
    repeat (2) step();
    send_byte(8'h77);
    check("ovr_flag", overrun, 1);
    check("ovr_data_a", data_a, 8'h0A);
    check("ovr_busy", busy, 1);
    check("ovr_tx_data", tx_data, 8'h0C);
    pulse_tx_done();
    send_byte(8'h01);
    send_byte(8'h06);
    send_byte(8'h20);
    step();
    check("ovr_next_a", data_a, 8'h01);
    check("ovr_next_tx", {tx_start, tx_data}, {1'b1, 8'h07});
    check("ovr_sticky", overrun, 1);
    pulse_tx_done();

    // Back-to-back: tx done in first WAIT_TX cycle.
    do_reset();
    check("b2b_ovr_cleared", overrun, 0);
    starts0 = n_starts;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h20);
    step();
    check("b2b_first_start", {tx_start, tx_data}, {1'b1, 8'h02});
    pulse_tx_done();
    check("b2b_idle", busy, 0);
    send_byte(8'hFF);
    send_byte(8'h01);
    send_byte(8'h20);
    step();
    check("b2b_second_start", {tx_start, tx_data}, {1'b1, 8'h00});
    pulse_tx_done();
    repeat (5) step();
    check("b2b_start_count", n_starts - starts0, 2);

    // Reset mid-transmit, asserted mid-cycle during the start pulse.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h20);
    step();
    #2 reset = 1'b0;
    #1;
    check("amid_async_clear", {tx_start, busy, overrun, timeout}, 0);
    check("amid_data", {data_a, data_b, operation, tx_data}, 0);
    starts0 = n_starts;
    step();
    reset = 1'b1;
    repeat (10) step();
    check("amid_no_start", n_starts - starts0, 0);
    check("amid_idle", busy, 0);

    // Partial frame followed by silence.
    do_reset();
    send_byte(8'h05);
`ifdef UART_ALU_INTF_TIMEOUT_EN
    hit = -1;
    for (int s = 0; s < 200 && hit < 0; s++) begin
      step();
      if (timeout) hit = s + 1;
    end
    // Pulse 100 cycles after the tick cycle, i.e. 99 steps after send returns.
    check("tmo_latency", hit, 99);
    step();
    check("tmo_one_cycle", timeout, 0);
    send_byte(8'h09);
    check("tmo_next_a", data_a, 8'h09);
    check("tmo_kept_b", data_b, 8'h00);
    // A byte in the expiry cycle is accepted and suppresses the timeout.
    repeat (98) step();
    send_byte(8'h33);
    check("tmo_race_b", data_b, 8'h33);
    check("tmo_race_none", timeout, 0);
`else
    hit = 0;
    for (int s = 0; s < 200; s++) begin
      step();
      if (timeout) hit++;
    end
    check("notmo_quiet", hit, 0);
    send_byte(8'h09);
    check("notmo_still_b", {data_a, data_b}, {8'h05, 8'h09});
`endif

    // Randomized frames against a frame-level model.
    do_reset();
    model_ovr = 1'b0;
    for (int f = 0; f < 40; f++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 8'($urandom);
      send_byte(ra);
      repeat ($urandom_range(0, 4)) step();
      if ($urandom_range(0, 3) == 0) pulse_tx_done();
      send_byte(rb);
      repeat ($urandom_range(0, 4)) step();
      send_byte(rop);
      step();
      check("rnd_start", tx_start, 1);
      check("rnd_tx_data", tx_data, 8'(ra + rb));
      check("rnd_operands", {data_a, data_b, operation}, {ra, rb, rop[5:0]});
      if ($urandom_range(0, 3) == 0) begin
        send_byte(8'($urandom));
        model_ovr = 1'b1;
      end
      repeat ($urandom_range(0, 3)) step();
      check("rnd_overrun", overrun, model_ovr);
      check("rnd_operands_held", {data_a, data_b}, {ra, rb});
      pulse_tx_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
